tdm_demux8: RTL and testbench
=============================

Name: tdm_demux8

Overview:
- Receiving end of the 8-slot time-division link, whose transmit side scans an 8:1 mux with a 3-bit select.
- Accepts one DW-bit word per slot, in slot order 0..7.
- Steers each word into the matching lane of a shadow register.
- Presents the completed 8-lane frame in parallel with a one-cycle frame_valid pulse.
- Detects framing errors: early frame_start, and a frame still incomplete when frame_start arrives.

Parameters:
- DW, 1, data bits per slot (legal range 1..8).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  block enable; when 0, inputs are ignored and all state holds (pulse outputs forced 0)
- in_valid  input  1  a slot word is present on d this cycle
- frame_start  input  1  qualifies in_valid: this word is slot 0 of a new frame
- d  input  DW  slot data word
- slot  output  3  slot index the next accepted word will be written to (s2,s1,s0 = slot[2:0])
- busy  output  1  1 while in RECV state
- Y  output  8*DW  last completed frame; lane k = Y[k*DW +: DW]
- frame_valid  output  1  one-cycle pulse, Y updated this cycle
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, slot=0, shadow=0, Y=0, frame_valid=0, frame_err=0, busy=0.
- Accept: acc = enable & in_valid. Nothing changes on cycles without acc, except that pulses return to 0.
- FSM state IDLE:
  - acc & frame_start: write d to shadow lane 0, slot->1, go RECV.
  - acc & !frame_start: word dropped, no error, stay IDLE.
- FSM state RECV:
  - acc & !frame_start: write d to shadow lane slot, slot->slot+1.
  - If the written slot was 7:
    - Y <= shadow with lane 7 = d (the full frame, including the current word), registered.
    - frame_valid=1 next cycle.
    - slot wraps to 0, state->IDLE.
  - acc & frame_start (slot != 0, i.e. an early restart):
    - frame_err=1 next cycle.
    - Partial frame discarded: shadow lanes 1..7 cleared.
    - d written to lane 0, slot->1, stay RECV.
    - Y unchanged.
- Latency: the last word is accepted at edge N; Y and frame_valid are visible after edge N (1-cycle registered). Minimum frame period is 8 cycles back-to-back: a frame_start accepted the cycle after slot 7 is legal, with no gap required.
- Simultaneous slot-7 completion and next frame: impossible in one cycle (one word per cycle). A frame_start in the next cycle finds IDLE, so no error.
- enable low mid-frame:
  - slot, shadow and state hold.
  - The frame resumes when enable returns.
  - No timeout.
- Reset mid-frame: shadow discarded and Y cleared immediately (async); no frame_valid or frame_err.
- Y holds its value until the next completed frame. frame_valid and frame_err never assert in the same cycle.
- Unused upper slot values: none; the 3-bit counter wraps naturally 7->0.

Decomposition:
- Shared package/header tdm_pkg: NSLOTS=8, SLOT_W=3, state encodings ST_IDLE=1'b0, ST_RECV=1'b1.
- The transmitter and this receiver both use that package.
- Sub-module lane_dec3x8: 3-to-8 one-hot decoder with enable, producing per-lane write strobes from slot and acc. It is the structural inverse of the transmit-side mux select.
- The rest is a single module.

Test Plan:
- Reset then clean frame, DW=1: frame_start with d=1 on cycle 0, then d=0,1,1,0,0,1,0 on the following 7 cycles, in_valid held high -> after the 8th edge, Y=8'b0100_1101, frame_valid high exactly 1 cycle, slot=0, busy=0.
- Back-to-back frames: two frames with no gap, Y=8'hA5 then 8'h3C -> frame_valid pulses exactly 8 cycles apart, frame_err never asserts.
- Early restart: frame_start at slot 4, then a full frame of 8'hFF -> frame_err pulses once, no frame_valid for the partial frame, then Y=8'hFF with frame_valid.
- Stall: in_valid or enable dropped for 5 cycles at slot 3 of frame 8'h96 -> slot holds at 3, then completion gives Y=8'h96. In IDLE, words without frame_start are dropped with no error.
- Async reset at slot 6 with Y=8'h3C held -> Y=0 immediately, slot=0, busy=0, no pulses. The next clean frame 8'h81 completes normally.
- DW=4: lane values 0..7 = 4'h1..4'h8 -> Y=32'h8765_4321.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tdm_pkg                                                   |
// | Purpose  : Constants and state encoding shared by both ends of the   |
// |            8-slot time-division link (transmit mux, receive demux).  |
// | Contents : NSLOTS, SLOT_W, state_t (ST_IDLE / ST_RECV)               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package tdm_pkg;

  localparam int NSLOTS = 8;
  localparam int SLOT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_demux8_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tdm_demux8_if                                             |
// | Purpose  : Slot-word input and frame output bundle of the receiver.  |
// | Ports    : enable, in_valid, frame_start, d[DW]  (towards receiver)  |
// |            slot[3], busy, Y[8*DW], frame_valid, frame_err (from it)  |
// | Modports : master - the link/consumer side, slave - the receiver     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface tdm_demux8_if #(
  parameter int DW = 1
);
  import tdm_pkg::*;

  logic                 enable;
  logic                 in_valid;
  logic                 frame_start;
  logic [DW-1:0]        d;
  logic [SLOT_W-1:0]    slot;
  logic                 busy;
  logic [NSLOTS*DW-1:0] Y;
  logic                 frame_valid;
  logic                 frame_err;

  modport master (
    output enable, in_valid, frame_start, d,
    input  slot, busy, Y, frame_valid, frame_err
  );

  modport slave (
    input  enable, in_valid, frame_start, d,
    output slot, busy, Y, frame_valid, frame_err
  );

endinterface : tdm_demux8_if
`default_nettype wire

// File: rtl/tdm_demux8_lane_dec3x8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lane_dec3x8                                               |
// | Purpose  : 3-to-8 one-hot decoder with enable; turns a slot index    |
// |            into per-lane write strobes (inverse of the tx mux sel).  |
// | Ports    : sel[3] in, en in, onehot[8] out                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module lane_dec3x8
  import tdm_pkg::*;
(
  input  wire logic [SLOT_W-1:0] sel,
  input  wire logic              en,
  output logic      [NSLOTS-1:0] onehot
);

  generate
    for (genvar k = 0; k < NSLOTS; k++) begin : g_lane
      assign onehot[k] = en && (sel == SLOT_W'(k));
    end
  endgenerate

endmodule : lane_dec3x8
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tdm_demux8                                                |
// | Purpose  : Receive side of the 8-slot TDM link. Steers one DW-bit    |
// |            word per slot into a shadow register, publishes the full  |
// |            frame on Y with a one-cycle frame_valid pulse, and flags  |
// |            early frame_start with a one-cycle frame_err pulse.       |
// | Ports    : clk, rst_n (async, active low), bus (tdm_demux8_if.slave) |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int DW = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  tdm_demux8_if.slave   bus
);

  localparam int FW = NSLOTS * DW;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     y_q, y_d;
  logic              fv_q, fv_d;
  logic              ferr_q, ferr_d;

  logic              acc;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;
  logic              clr_partial;
  logic              complete;
  logic [NSLOTS-1:0] wr_strobe;

  assign acc = bus.enable && bus.in_valid;

  // Control: decides which lane is written and what the frame events are.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    fv_d        = 1'b0;
    ferr_d      = 1'b0;
    wr_en       = 1'b0;
    wr_slot     = slot_q;
    clr_partial = 1'b0;
    complete    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Words without frame_start are silently dropped while idle.
        if (acc && bus.frame_start) begin
          wr_en   = 1'b1;
          wr_slot = '0;
          slot_d  = SLOT_W'(1);
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (acc) begin
          if (bus.frame_start) begin
            // Early restart: slot is never 0 in RECV, so this is always an error.
            ferr_d      = 1'b1;
            clr_partial = 1'b1;
            wr_en       = 1'b1;
            wr_slot     = '0;
            slot_d      = SLOT_W'(1);
          end else begin
            wr_en  = 1'b1;
            slot_d = slot_q + SLOT_W'(1);
            if (slot_q == SLOT_W'(NSLOTS - 1)) begin
              complete = 1'b1;
              fv_d     = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lane_dec3x8 u_lane_dec (
    .sel    (wr_slot),
    .en     (wr_en),
    .onehot (wr_strobe)
  );

  // Datapath: lane writes, partial-frame clear, and frame publication.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NSLOTS; k++) begin
      if (wr_strobe[k]) begin
        shadow_d[k*DW +: DW] = bus.d;
      end else if (clr_partial && (k != 0)) begin
        shadow_d[k*DW +: DW] = '0;
      end
    end
    // shadow_d already carries the slot-7 word, so Y gets the whole frame.
    y_d = complete ? shadow_d : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.slot        = slot_q;
  assign bus.busy        = (state_q == ST_RECV);
  assign bus.Y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = ferr_q;

endmodule : tdm_demux8
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tdm_demux8                                             |
// | Purpose  : Directed self-checking bench for tdm_demux8, covering a   |
// |            DW=1 instance (framing behaviour) and a DW=4 instance.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tdm_demux8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fv1_cnt  = 0;
  int ferr1_cnt = 0;
  int fv1_cyc  = 0;

  tdm_demux8_if #(.DW(1)) b1 ();
  tdm_demux8_if #(.DW(4)) b4 ();

  tdm_demux8 #(.DW(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  tdm_demux8 #(.DW(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Advance one clock edge and sample 1 ns later; tally DW=1 pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (b1.frame_valid) begin
      fv1_cnt++;
      fv1_cyc = cyc;
    end
    if (b1.frame_err) ferr1_cnt++;
  endtask

  task automatic word1(input logic fs, input logic db);
    b1.in_valid    = 1'b1;
    b1.frame_start = fs;
    b1.d           = db;
    tick();
  endtask

  task automatic idle1();
    b1.in_valid    = 1'b0;
    b1.frame_start = 1'b0;
    tick();
  endtask

  task automatic send_frame1(input logic [7:0] v);
    for (int k = 0; k < 8; k++) word1(k == 0, v[k]);
  endtask

  int c_a, fv0, ferr0;

  initial begin
    rst_n = 1'b0;
    b1.enable = 1'b1; b1.in_valid = 1'b0; b1.frame_start = 1'b0; b1.d = '0;
    b4.enable = 1'b1; b4.in_valid = 1'b0; b4.frame_start = 1'b0; b4.d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_Y",     32'(b1.Y), 32'h0);
    check("rst_slot",  32'(b1.slot), 32'd0);
    check("rst_busy",  32'(b1.busy), 32'd0);
    check("rst_fv",    32'(b1.frame_valid), 32'd0);
    check("rst_ferr",  32'(b1.frame_err), 32'd0);
    check("rst_Y4",    b4.Y, 32'h0);

    // Clean frame: lanes 0..7 = 1,0,1,1,0,0,1,0
    word1(1'b1, 1'b1);
    check("f1_slot_after0", 32'(b1.slot), 32'd1);
    check("f1_busy", 32'(b1.busy), 32'd1);
    word1(0, 0); word1(0, 1); word1(0, 1); word1(0, 0);
    word1(0, 0); word1(0, 1);
    check("f1_no_early_fv", 32'(b1.frame_valid), 32'd0);
    word1(0, 0);
    check("f1_Y",     32'(b1.Y), 32'h4D);
    check("f1_fv",    32'(b1.frame_valid), 32'd1);
    check("f1_slot",  32'(b1.slot), 32'd0);
    check("f1_busy0", 32'(b1.busy), 32'd0);
    idle1();
    check("f1_fv_1cyc", 32'(b1.frame_valid), 32'd0);
    check("f1_Y_hold",  32'(b1.Y), 32'h4D);

    // Back-to-back frames
    send_frame1(8'hA5);
    check("b2b_Y_A5", 32'(b1.Y), 32'hA5);
    c_a = fv1_cyc;
    send_frame1(8'h3C);
    check("b2b_Y_3C", 32'(b1.Y), 32'h3C);
    check("b2b_fv",   32'(b1.frame_valid), 32'd1);
    check("b2b_period", 32'(fv1_cyc - c_a), 32'd8);
    check("b2b_no_err", 32'(ferr1_cnt), 32'd0);

    // Early restart at slot 4, then a full frame of 1s
    fv0 = fv1_cnt; ferr0 = ferr1_cnt;
    for (int k = 0; k < 4; k++) word1(k == 0, 1'b1);
    check("er_slot4", 32'(b1.slot), 32'd4);
    word1(1'b1, 1'b1);
    check("er_ferr",  32'(b1.frame_err), 32'd1);
    check("er_no_fv", 32'(b1.frame_valid), 32'd0);
    check("er_slot1", 32'(b1.slot), 32'd1);
    check("er_Y_kept", 32'(b1.Y), 32'h3C);
    for (int k = 1; k < 8; k++) word1(1'b0, 1'b1);
    check("er_Y_FF",   32'(b1.Y), 32'hFF);
    check("er_fv",     32'(b1.frame_valid), 32'd1);
    check("er_fv_cnt", 32'(fv1_cnt - fv0), 32'd1);
    check("er_err_cnt", 32'(ferr1_cnt - ferr0), 32'd1);
    idle1();

    // Stall at slot 3 of 8'h96 (lanes 0..7 = 0,1,1,0,1,0,0,1)
    ferr0 = ferr1_cnt;
    word1(1, 0); word1(0, 1); word1(0, 1);
    for (int k = 0; k < 5; k++) begin
      b1.in_valid = 1'b0; b1.frame_start = 1'b1; b1.d = 1'b1;
      tick();
    end
    check("st_iv_slot", 32'(b1.slot), 32'd3);
    check("st_iv_busy", 32'(b1.busy), 32'd1);
    b1.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b1.in_valid = 1'b1; b1.frame_start = 1'b1; b1.d = 1'b1;
      tick();
    end
    check("st_en_slot", 32'(b1.slot), 32'd3);
    b1.enable = 1'b1;
    word1(0, 0); word1(0, 1); word1(0, 0); word1(0, 0); word1(0, 1);
    check("st_Y_96", 32'(b1.Y), 32'h96);
    check("st_fv",   32'(b1.frame_valid), 32'd1);
    for (int k = 0; k < 3; k++) word1(1'b0, 1'b1);
    check("idle_drop_slot", 32'(b1.slot), 32'd0);
    check("idle_drop_busy", 32'(b1.busy), 32'd0);
    check("idle_drop_Y",    32'(b1.Y), 32'h96);
    check("st_no_err",      32'(ferr1_cnt - ferr0), 32'd0);

    // Async reset at slot 6 with Y = 3C
    send_frame1(8'h3C);
    for (int k = 0; k < 6; k++) word1(k == 0, 1'b1);
    check("ar_slot6", 32'(b1.slot), 32'd6);
    b1.in_valid = 1'b0; b1.frame_start = 1'b0;
    fv0 = fv1_cnt; ferr0 = ferr1_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("ar_Y0",    32'(b1.Y), 32'h0);
    check("ar_slot0", 32'(b1.slot), 32'd0);
    check("ar_busy0", 32'(b1.busy), 32'd0);
    #1 rst_n = 1'b1;
    idle1(); idle1();
    check("ar_no_pulse", 32'((fv1_cnt - fv0) + (ferr1_cnt - ferr0)), 32'd0);
    send_frame1(8'h81);
    check("ar_Y_81", 32'(b1.Y), 32'h81);
    check("ar_fv",   32'(b1.frame_valid), 32'd1);
    idle1();

    // DW = 4: lanes 0..7 = 1..8
    for (int k = 0; k < 8; k++) begin
      b4.in_valid    = 1'b1;
      b4.frame_start = (k == 0);
      b4.d           = 4'(k + 1);
      tick();
    end
    b4.in_valid = 1'b0;
    check("dw4_Y",  b4.Y, 32'h8765_4321);
    check("dw4_fv", 32'(b4.frame_valid), 32'd1);
    tick();
    check("dw4_fv_1cyc", 32'(b4.frame_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tdm_demux8
`default_nettype wire
